// File: rtl/fifo_write_scheduler.sv
// Round-robin scheduler sharing one FIFO write port among NUM_WRITERS writers
// over the req/busy handshake, with full backpressure and a saturating stall count.
module fifo_write_scheduler #(
   parameter int unsigned NUM_WRITERS = 4,
   parameter int unsigned DATA_WIDTH  = 8
) (
   input  logic                               i_clk,
   input  logic                               i_reset_n,
   input  logic [NUM_WRITERS*DATA_WIDTH-1:0]  i_data,
   input  logic [NUM_WRITERS-1:0]             i_req,
   output logic [NUM_WRITERS-1:0]             o_busy,
   input  logic                               i_full,
   output logic [DATA_WIDTH-1:0]              o_data,
   output logic                               o_we,
   output logic [$clog2(NUM_WRITERS)-1:0]     o_last_grant,
   output logic [15:0]                        o_stall_cnt
);

   localparam int unsigned IDX_W = $clog2(NUM_WRITERS);
   localparam logic [IDX_W:0]   NW   = (IDX_W+1)'(NUM_WRITERS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WRITERS - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                  state, state_nx;
   logic [IDX_W-1:0]        ptr, ptr_nx;
   logic [NUM_WRITERS-1:0]  busy_nx;
   logic [DATA_WIDTH-1:0]   data_nx;
   logic                    we_nx;
   logic [IDX_W-1:0]        last_nx;
   logic [15:0]             stall_nx;

   logic                    found;
   logic [IDX_W-1:0]        win;
   logic [IDX_W:0]          cand;
   logic [DATA_WIDTH-1:0]   win_data;

   // Search starts at ptr; the extra index bit lets the wrap work for any count.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_WRITERS; i++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(i);
         if (cand >= NW) cand = cand - NW;
         if (!found && i_req[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            win   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int unsigned k = 0; k < NUM_WRITERS; k++) begin
         if (win == IDX_W'(k)) win_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      busy_nx  = '1;
      data_nx  = o_data;
      we_nx    = 1'b0;
      last_nx  = o_last_grant;
      stall_nx = o_stall_cnt;
      case (state)
         IDLE: begin
            if (found && !i_full) begin
               for (int unsigned k = 0; k < NUM_WRITERS; k++) begin
                  busy_nx[k] = (win != IDX_W'(k));
               end
               data_nx  = win_data;
               we_nx    = 1'b1;
               last_nx  = win;
               ptr_nx   = (win == LAST) ? '0 : win + 1'b1;
               state_nx = GRANT;
            end else if (found && (o_stall_cnt != '1)) begin
               stall_nx = o_stall_cnt + 16'd1;
            end
         end
         GRANT: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state        <= IDLE;
         ptr          <= '0;
         o_busy       <= '1;
         o_data       <= '0;
         o_we         <= 1'b0;
         o_last_grant <= '0;
         o_stall_cnt  <= '0;
      end else begin
         state        <= state_nx;
         ptr          <= ptr_nx;
         o_busy       <= busy_nx;
         o_data       <= data_nx;
         o_we         <= we_nx;
         o_last_grant <= last_nx;
         o_stall_cnt  <= stall_nx;
      end
   end

endmodule

// File: tb/tb_fifo_write_scheduler.sv
// Bench for fifo_write_scheduler: directed and random stimulus against a
// transaction-level reference model, plus a 3-writer instance for odd wrap.
module tb_fifo_write_scheduler;

   localparam int N = 4;
   localparam int D = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N*D-1:0] data_in;
   logic [N-1:0]  req;
   logic          full;
   logic [N-1:0]  busy;
   logic [D-1:0]  data_out;
   logic          we;
   logic [1:0]    last_grant;
   logic [15:0]   stall_cnt;

   logic          rst3_n;
   logic [23:0]   data3;
   logic [2:0]    req3;
   logic [2:0]    busy3;
   logic [7:0]    dout3;
   logic          we3;
   logic [1:0]    lg3;
   logic [15:0]   stall3;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit            m_in_grant;
   int            m_ptr;
   logic [N-1:0]  m_busy;
   logic          m_we;
   logic [D-1:0]  m_data;
   int            m_lg;
   int            m_stall;

   always #5 clk = ~clk;

   fifo_write_scheduler #(.NUM_WRITERS(N), .DATA_WIDTH(D)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_data(data_in), .i_req(req),
      .o_busy(busy), .i_full(full), .o_data(data_out), .o_we(we),
      .o_last_grant(last_grant), .o_stall_cnt(stall_cnt)
   );

   fifo_write_scheduler #(.NUM_WRITERS(3), .DATA_WIDTH(8)) dut3 (
      .i_clk(clk), .i_reset_n(rst3_n), .i_data(data3), .i_req(req3),
      .o_busy(busy3), .i_full(1'b0), .o_data(dout3), .o_we(we3),
      .o_last_grant(lg3), .o_stall_cnt(stall3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A transaction either grants a writer (busy pulse + write) or is refused by full.
   task automatic model_update();
      int k;
      if (!rst_n) begin
         m_in_grant = 0; m_ptr = 0; m_busy = '1; m_we = 0;
         m_data = '0; m_lg = 0; m_stall = 0;
      end else if (m_in_grant) begin
         m_in_grant = 0; m_busy = '1; m_we = 0;
      end else if (req != 0) begin
         if (full) begin
            if (m_stall < 65535) m_stall++;
         end else begin
            k = -1;
            for (int j = 0; j < N; j++)
               if (k < 0 && req[(m_ptr + j) % N]) k = (m_ptr + j) % N;
            m_in_grant = 1;
            m_busy = '1;
            m_busy[k] = 1'b0;
            m_we   = 1;
            m_data = data_in[k*D +: D];
            m_lg   = k;
            m_ptr  = (k + 1) % N;
         end
      end
   endtask

   task automatic check_all();
      chk("busy", busy, m_busy);
      chk("we", we, m_we);
      chk("data", data_out, m_data);
      chk("last_grant", last_grant, m_lg);
      chk("stall", stall_cnt, m_stall);
   endtask

   task automatic step(input bit do_check);
      @(posedge clk);
      model_update();
      #1;
      if (do_check) check_all();
   endtask

   initial begin
      rst_n = 0; req = '1; full = 0; data_in = 32'h44332211;
      rst3_n = 0; req3 = '0; data3 = 24'h030201;

      // reset held 3 cycles with requests pending
      repeat (3) step(1);
      chk("reset_busy", busy, 4'b1111);
      chk("reset_we", we, 1'b0);
      chk("reset_stall", stall_cnt, 16'd0);
      rst_n = 1;
      step(1);
      chk("first_grant", last_grant, 2'd0);
      chk("first_busy", busy, 4'b1110);
      step(1);

      // single request
      req = 4'b0100; data_in = 32'h00A50000;
      step(1);
      chk("single_busy", busy, 4'b1011);
      chk("single_data", data_out, 8'hA5);
      chk("single_lg", last_grant, 2'd2);
      req = 4'b0000;
      step(1);
      chk("single_release", busy, 4'b1111);

      // rotation with all requesting
      req = 4'b1111; data_in = 32'hD4C3B2A1;
      repeat (10) step(1);

      // wrap / skip: drive until writer 3 has been granted, then 0110
      for (int n = 0; n < 8 && !(we && last_grant == 2'd3); n++) step(1);
      chk("wrap_reached3", last_grant, 2'd3);
      req = 4'b0110;
      step(1);
      step(1);
      chk("skip_to_1", last_grant, 2'd1);
      step(1);
      step(1);
      chk("then_2", last_grant, 2'd2);
      step(1);

      // backpressure from a fresh reset
      rst_n = 0; req = 4'b0001; full = 1;
      step(1);
      rst_n = 1;
      repeat (5) step(1);
      chk("stall5", stall_cnt, 16'd5);
      chk("stall_busy", busy, 4'b1111);
      full = 0;
      step(1);
      chk("unstall_grant", busy, 4'b1110);
      step(1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         req     = N'($urandom);
         full    = ($urandom_range(0, 3) == 0);
         data_in = $urandom;
         step(1);
      end

      // reset during GRANT
      full = 0; req = 4'b1000;
      for (int n = 0; n < 4 && !we; n++) step(1);
      chk("pre_abort_we", we, 1'b1);
      rst_n = 0;
      step(1);
      chk("abort_busy", busy, 4'b1111);
      chk("abort_we", we, 1'b0);
      rst_n = 1; req = 4'b1111;
      step(1);
      chk("abort_ptr0", last_grant, 2'd0);
      step(1);

      // stall saturation
      full = 1; req = 4'b0010;
      repeat (70000) step(0);
      check_all();
      chk("stall_sat", stall_cnt, 16'hFFFF);
      full = 0; req = '0;

      // three-writer instance: odd-count wrap 0,1,2,0
      step(1);
      rst3_n = 1; req3 = 3'b111;
      for (int g = 0; g < 4; g++) begin
         step(1);
         chk("n3_order", lg3, (g % 3));
         chk("n3_data", dout3, (g % 3) + 1);
         chk("n3_we", we3, 1'b1);
         step(1);
         chk("n3_idle", busy3, 3'b111);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
